// File: rtl/result_serializer_pkg.sv
// Shared types and sizing helpers for result_serializer.
// RESULT_SERIALIZER_PARITY_EN appends an even-parity beat to every word.
package result_serializer_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

`ifdef RESULT_SERIALIZER_PARITY_EN
  localparam int unsigned ExtraBeats = 1;
`else
  localparam int unsigned ExtraBeats = 0;
`endif

  function automatic int unsigned beats_per_word(input int unsigned num_cols);
    return num_cols + ExtraBeats;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned num_cols);
    return $clog2(num_cols + 2);
  endfunction

endpackage

// File: rtl/result_serializer.sv
// Parallel-load, LSB-first serializer for the compressor column outputs.
// Build option: RESULT_SERIALIZER_PARITY_EN adds a trailing even-parity beat.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int unsigned NUM_COLS = 63,
  localparam int unsigned CNT_W = cnt_width(NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [NUM_COLS-1:0] dst_in,
  output logic                ser_out,
  output logic                ser_valid,
  output logic                ser_last,
  input  logic                ser_ready
);

  localparam int unsigned Beats = beats_per_word(NUM_COLS);

  state_e           state_q;
  logic [Beats-1:0] shreg_q;
  logic [Beats-1:0] load_word;
  logic [CNT_W-1:0] cnt_q;
  logic             last_beat;
  logic             xfer;
  logic             load_fire;

`ifdef RESULT_SERIALIZER_PARITY_EN
  // Parity rides above the data so the plain right shift delivers it last.
  assign load_word = {^dst_in, dst_in};
`else
  assign load_word = dst_in;
`endif

  assign last_beat  = (state_q == StShift) && (cnt_q == CNT_W'(Beats - 1));
  assign xfer       = (state_q == StShift) && ser_ready;
  // Ready in SHIFT only while the final beat is leaving, giving bubble-free reloads.
  assign load_ready = !rst && ((state_q == StIdle) || (last_beat && ser_ready));
  assign load_fire  = load_valid && load_ready;

  assign ser_valid = (state_q == StShift);
  assign ser_out   = shreg_q[0];
  assign ser_last  = last_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (load_fire) begin
      state_q <= StShift;
      shreg_q <= load_word;
      cnt_q   <= '0;
    end else if (xfer) begin
      shreg_q <= shreg_q >> 1;
      if (last_beat) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: directed scenarios plus random data and
// backpressure, checked against a queue-of-beats reference model.
module tb_result_serializer;

  localparam int unsigned NC    = 63;
  localparam int unsigned BEATS = result_serializer_pkg::beats_per_word(NC);

  logic          clk;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [NC-1:0] dst_in;
  logic          ser_out;
  logic          ser_valid;
  logic          ser_last;
  logic          ser_ready;

  result_serializer #(
    .NUM_COLS(NC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .dst_in    (dst_in),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .ser_ready (ser_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } beat_t;

  beat_t q[$];
  int    total = 0;
  int    bad = 0;
  bit    fired;
  int    run_len;
  int    max_run;

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NC-1:0] rand_word();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[NC-1:0];
  endfunction

  task automatic push_word(input logic [NC-1:0] w);
    for (int i = 0; i < int'(NC); i++) q.push_back('{b: w[i], last: (i == int'(BEATS) - 1)});
`ifdef RESULT_SERIALIZER_PARITY_EN
    q.push_back('{b: ^w, last: 1'b1});
`endif
  endtask

  // One clock: drive, check combinational view mid-cycle, then advance the model at the edge.
  task automatic step(input logic i_rst, input logic i_lv, input logic [NC-1:0] i_dst,
                      input logic i_rdy);
    logic exp_valid;
    logic exp_lr;
    rst        = i_rst;
    load_valid = i_lv;
    dst_in     = i_dst;
    ser_ready  = i_rdy;
    #1;
    exp_valid = (q.size() != 0);
    exp_lr    = !i_rst && ((q.size() == 0) || ((q.size() == 1) && i_rdy));
    check1("ser_valid", ser_valid, exp_valid);
    check1("load_ready", load_ready, exp_lr);
    check1("ser_out", ser_out, exp_valid ? q[0].b : 1'b0);
    check1("ser_last", ser_last, exp_valid ? q[0].last : 1'b0);
    if (ser_valid) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
    @(posedge clk);
    fired = 1'b0;
    if (i_rst) begin
      q.delete();
    end else begin
      if (exp_valid && i_rdy) void'(q.pop_front());
      if (i_lv && exp_lr) begin
        push_word(i_dst);
        fired = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input bit rand_rdy);
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      step(1'b0, 1'b0, rand_word(), rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    checkn("drain_bound", q.size(), 0);
  endtask

  task automatic load_until_taken(input logic [NC-1:0] w, input bit rand_rdy);
    int n;
    n = 0;
    fired = 1'b0;
    while (!fired && n < 2000) begin
      step(1'b0, 1'b1, w, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    check1("load_bound", fired, 1'b1);
  endtask

  initial begin
    logic [NC-1:0] w;
    run_len = 0;
    max_run = 0;
    rst        = 1'b1;
    load_valid = 1'b1;
    dst_in     = rand_word();
    ser_ready  = 1'b1;

    // Reset: three cycles with load_valid asserted; first edge puts the DUT in a known state.
    @(posedge clk);
    @(negedge clk);
    step(1'b1, 1'b1, rand_word(), 1'b1);
    step(1'b1, 1'b1, rand_word(), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    check1("idle_ready_after_rst", load_ready, 1'b1);

    // Single words, ready held high.
    w = 63'h1;
    load_until_taken(w, 1'b0);
    drain(1'b0);
    w = 63'h4000_0000_0000_0001;
    load_until_taken(w, 1'b0);
    drain(1'b0);

    // Backpressure with random ready.
    w = 63'h5555_5555_5555_5555;
    load_until_taken(w, 1'b1);
    drain(1'b1);

    // Back-to-back words with no bubble.
    step(1'b0, 1'b0, '0, 1'b1);
    max_run = 0;
    run_len = 0;
    w = 63'h7FFF_FFFF_FFFF_FFFF;
    load_until_taken(w, 1'b0);
    w = 63'h0;
    load_until_taken(w, 1'b0);
    drain(1'b0);
    checkn("b2b_contiguous_beats", max_run, 2 * int'(BEATS));

    // Mid-word reset, then a fresh word restarts from bit 0.
    load_until_taken(rand_word(), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    w = 63'h3;
    load_until_taken(w, 1'b0);
    drain(1'b0);

    // Load request during beat 10 is ignored.
    load_until_taken(rand_word(), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, rand_word(), 1'b1);
    check1("ignored_load", fired, 1'b0);
    drain(1'b0);
    step(1'b0, 1'b0, rand_word(), 1'b1);
    step(1'b0, 1'b0, rand_word(), 1'b1);

    // Random words, random gaps and random backpressure.
    for (int k = 0; k < 6; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step(1'b0, 1'b0, rand_word(), 1'b1);
      load_until_taken(rand_word(), 1'b1);
      if ($urandom_range(0, 1) == 1) load_until_taken(rand_word(), 1'b1);
      drain(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
